// File: rtl/assignments_pkg.sv
// Shared types and sizes for the nonogram assignment collector.
// Word width, store depth and index width live here.
package assignments_pkg;

  localparam int ASSIGN_WIDTH = 20;
  localparam int ASSIGN_DEPTH = 20;
  localparam int ASSIGN_IDX_W = 6;

  typedef logic [ASSIGN_WIDTH-1:0] assignment_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2,
    ERROR   = 2'd3
  } collector_state_t;

endpackage

// File: rtl/assignments_store.sv
// DEPTH x WIDTH register array: one write port, one registered read port.
// Synchronous clear wipes every entry and the read register.
module assignments_store
  import assignments_pkg::*;
#(
  parameter int WIDTH = ASSIGN_WIDTH,
  parameter int DEPTH = ASSIGN_DEPTH,
  parameter int IDX_W = ASSIGN_IDX_W
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read; read sees the pre-write value.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i && (waddr_i < DEPTH_C)) begin
        mem_q[waddr_i[AW-1:0]] <= wdata_i;
      end
      if (raddr_i < DEPTH_C) begin
        rdata_q <= mem_q[raddr_i[AW-1:0]];
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/assignments_collector.sv
// Receive side of the assignment stream: in-order capture, status, read port.
// Define ASSIGN_CHECKSUM_EN to add the running-XOR checksum_out port.
module assignments_collector
  import assignments_pkg::*;
#(
  parameter int WIDTH = ASSIGN_WIDTH,
  parameter int DEPTH = ASSIGN_DEPTH,
  parameter int IDX_W = ASSIGN_IDX_W
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             arm_in,
  input  logic [WIDTH-1:0] assignment_in,
  input  logic [IDX_W-1:0] index_in,
  input  logic             valid_in,
  input  logic             done_in,
  input  logic [IDX_W-1:0] rd_addr_in,
  output logic [WIDTH-1:0] rd_data_out,
  output logic [IDX_W-1:0] count_out,
  output logic             busy_out,
  output logic             ready_out,
  output logic             error_out
`ifdef ASSIGN_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum_out
`endif
);

  localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);

  collector_state_t state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             bad;

  // Capture FSM: in-order check, overflow check, done evaluation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_en   = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (arm_in) begin
          count_d = '0;
        end else begin
          if (valid_in) begin
            if ((index_in == count_q) && (count_q < DEPTH_C)) begin
              wr_en   = 1'b1;
              count_d = count_q + IDX_W'(1);
            end else begin
              bad = 1'b1;
            end
          end
          if (bad) begin
            state_d = ERROR;
          end else if (done_in) begin
            state_d = (count_d == DEPTH_C) ? READY : ERROR;
          end
        end
      end
      default: begin
        if (arm_in) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
    endcase
  end

  // State and count registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef ASSIGN_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  // Running XOR of accepted words, restarted on every arm.
  always_comb begin
    csum_d = csum_q;
    if (arm_in) begin
      csum_d = '0;
    end else if (wr_en) begin
      csum_d = csum_q ^ assignment_in;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum_out = csum_q;
`endif

  assignments_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_store (
    .clk_i   (clk_in),
    .clr_i   (reset_in),
    .we_i    (wr_en),
    .waddr_i (index_in),
    .wdata_i (assignment_in),
    .raddr_i (rd_addr_in),
    .rdata_o (rd_data_out)
  );

  assign count_out = count_q;
  assign busy_out  = (state_q == COLLECT);
  assign ready_out = (state_q == READY);
  assign error_out = (state_q == ERROR);

endmodule

// File: doc/assignments_collector.md
Name: assignments_collector

Overview:
- Receive end of the nonogram clue-assignment stream: captures the 20-bit assignment words streamed by the ROM-reader block (word, index, sending, done).
- Holds them in a local register array.
- Exposes a synchronous random-read port to the solver/display logic, with ready/error status.
- Sits between the assignment ROM streamer and the solver, one clock domain.

Parameters:
- WIDTH, 20, bits per assignment word.
- DEPTH, 20, number of words expected per nonogram.
- IDX_W, 6, width of index, count and read-address buses.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  synchronous, active-high reset
- arm_in  input  1  one-cycle pulse: clear store state and begin collecting
- assignment_in  input  WIDTH  streamed assignment word
- index_in  input  IDX_W  sender's word index for assignment_in
- valid_in  input  1  assignment_in/index_in valid this cycle (sender "sending")
- done_in  input  1  sender end-of-stream pulse
- rd_addr_in  input  IDX_W  read address
- rd_data_out  output  WIDTH  registered read data
- count_out  output  IDX_W  words captured so far
- busy_out  output  1  high in COLLECT
- ready_out  output  1  high in READY (full, consistent set captured)
- error_out  output  1  high in ERROR (sticky until arm_in or reset)
- checksum_out  output  WIDTH  present only with ASSIGN_CHECKSUM_EN

Behaviour:
- Reset (synchronous, active-high, clk_in):
  - state=IDLE.
  - count_out=0, busy_out=0, ready_out=0, error_out=0, rd_data_out=0, checksum_out=0.
  - All DEPTH store entries cleared to 0.
  - Reset mid-collection discards partial data.
- States: IDLE, COLLECT, READY, ERROR. Outputs are registered and reflect the state on the cycle after the transition.
- IDLE/READY/ERROR + arm_in → COLLECT:
  - count_out←0, checksum←0, ready/error cleared.
  - Store contents are not cleared.
- COLLECT + arm_in → restart COLLECT with count_out←0. arm_in has priority over valid_in/done_in in the same cycle.
- COLLECT + valid_in:
  - If index_in==count_out and count_out<DEPTH: write store[index_in]←assignment_in, count_out++.
  - If index_in≠count_out: → ERROR (out-of-order).
  - If count_out==DEPTH: → ERROR (overflow).
- COLLECT + done_in:
  - Evaluated after any same-cycle valid_in write, using the post-write count.
  - count==DEPTH → READY.
  - count<DEPTH → ERROR (underflow).
  - If the same-cycle valid_in already caused ERROR, the result stays ERROR.
- valid_in/done_in outside COLLECT: ignored, no state change.
- Read port:
  - rd_data_out←store[rd_addr_in] one cycle after the address is presented, in any state.
  - rd_addr_in≥DEPTH returns 0.
  - A read and a write to the same address in one cycle returns the old value.
- count_out saturates at DEPTH. All index arithmetic is unsigned IDX_W.

Optional Feature:
- Macro: ASSIGN_CHECKSUM_EN.
- Defined:
  - checksum_out is a running XOR of every accepted word; cleared on arm_in and on reset.
  - It is valid when ready_out=1.
- Undefined: checksum_out port and XOR register are absent. All other behaviour is identical.

Decomposition:
- Shared package assignments_pkg holds:
  - ASSIGN_WIDTH=20, ASSIGN_DEPTH=20, ASSIGN_IDX_W=6.
  - typedef assignment_t (logic [19:0]).
  - enum collector_state_t {IDLE, COLLECT, READY, ERROR}.
- One sub-module: assignments_store, a DEPTH×WIDTH register array with one write port, one registered read port, and a synchronous clear. The FSM stays in the top module.

Test Plan:
- Reset, arm_in, then 20 words 0x00001..0x00014 with index 0..19 and done_in on the cycle after the last word → ready_out=1, count_out=20, error_out=0. Reading addr 7 returns 0x00008 one cycle later.
- Arm, send index 0,1 then index 3 → error_out=1 on the cycle after index 3, count_out=2. A further valid_in is ignored. A new arm_in clears error_out.
- Arm, send 12 words, then done_in → ERROR, count_out=12. rd_addr_in=25 → rd_data_out=0.
- Arm, send 20 words, then a 21st valid_in with index 20 → ERROR (overflow). Separately, the 20th word and done_in in the same cycle → READY.
- reset_in asserted after 10 words → next cycle IDLE, count_out=0, rd_data_out of addr 3 = 0. arm_in asserted during collection after 5 words → count_out=0, and reception restarts from index 0.
- With ASSIGN_CHECKSUM_EN: words 0xFFFFF, 0x0000F, then 18 zeros → checksum_out=0xFFFF0 at ready_out=1.
